// File: rtl/viterbi_pkg.sv
// Shared sizing and FSM encoding for the Viterbi traceback slice.
// VITERBI_TB_FWD_ORDER_EN adds the FILL state used for forward-order emission.
package viterbi_pkg;

  localparam int N_STATES = 8;
  localparam int SW       = 3;
  localparam int T_MAX    = 64;
  localparam int TW       = 6;

`ifdef VITERBI_TB_FWD_ORDER_EN
  typedef enum logic [1:0] {IDLE, COLLECT, TRACE, FILL} state_e;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, TRACE} state_e;
`endif

endpackage

// File: rtl/viterbi_traceback_if.sv
// Decoded-path valid/ready stream from the traceback to the path consumer.
interface viterbi_traceback_if
  import viterbi_pkg::*;
();

  logic          path_valid;
  logic [SW-1:0] path_state;
  logic [TW-1:0] path_step;
  logic          path_last;
  logic          path_ready;

  modport master (
    output path_valid, path_state, path_step, path_last,
    input  path_ready
  );

  modport slave (
    input  path_valid, path_state, path_step, path_last,
    output path_ready
  );

endinterface

// File: rtl/viterbi_bp_mem.sv
// Backpointer store: (T_MAX-1) rows x N_STATES entries, sync write, async read.
module viterbi_bp_mem
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [TW-1:0] wr_row,
  input  logic [SW-1:0] wr_col,
  input  logic [SW-1:0] wr_data,
  input  logic [TW-1:0] rd_row,
  input  logic [SW-1:0] rd_col,
  output logic [SW-1:0] rd_data
);

  logic [SW-1:0] mem [T_MAX-1][N_STATES];

  always_ff @(posedge clk) begin
    if (we) mem[wr_row][wr_col] <= wr_data;
  end

  assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/viterbi_traceback.sv
// Collects per-step backpointers and walks them back from the final best state.
// Define VITERBI_TB_FWD_ORDER_EN to emit the path in ascending step order via a LIFO.
module viterbi_traceback
  import viterbi_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seq_start,
  input  logic                bp_valid,
  input  logic [SW-1:0]       bp_state,
  input  logic [31:0]         bp_idx,
  input  logic                bp_step_done,
  input  logic                final_valid,
  input  logic [SW-1:0]       final_state,
  viterbi_traceback_if.master path,
  output logic                busy,
  output logic                err_overflow
);

  state_e        state, state_n;
  logic [TW-1:0] t_cnt, t_cnt_post, n, rd_row;
  logic [SW-1:0] s, rd_data;
  logic          in_collect, at_top, bp_state_ok, wr_en, hs;
  logic          unused_idx_hi;

  assign unused_idx_hi = ^bp_idx[31:SW];

  assign in_collect  = (state == COLLECT) && !seq_start;
  assign at_top      = (t_cnt == TW'(T_MAX - 1));
  assign bp_state_ok = ({1'b0, bp_state} < (SW + 1)'(N_STATES));
  assign wr_en       = in_collect && bp_valid && bp_state_ok && !at_top;
  // final_valid sees the row count after a same-cycle step close
  assign t_cnt_post  = (in_collect && bp_step_done && !at_top) ? t_cnt + 1'b1 : t_cnt;
  assign hs          = path.path_valid && path.path_ready;
  assign rd_row      = n - 1'b1;

  viterbi_bp_mem u_mem (
    .clk     (clk),
    .we      (wr_en),
    .wr_row  (t_cnt),
    .wr_col  (bp_state),
    .wr_data (bp_idx[SW-1:0]),
    .rd_row  (rd_row),
    .rd_col  (s),
    .rd_data (rd_data)
  );

`ifdef VITERBI_TB_FWD_ORDER_EN
  logic [SW-1:0] lifo [T_MAX];
  logic [TW:0]   ptr, ptr_m1;

  assign ptr_m1 = ptr - 1'b1;

  always_ff @(posedge clk) begin
    if (state == FILL) lifo[ptr[TW-1:0]] <= s;
  end

  assign path.path_state = path.path_valid ? lifo[ptr_m1[TW-1:0]] : '0;
  assign path.path_last  = path.path_valid && (ptr == (TW + 1)'(1));
`else
  assign path.path_state = path.path_valid ? s : '0;
  assign path.path_last  = path.path_valid && (n == '0);
`endif

  assign path.path_valid = (state == TRACE);
  assign path.path_step  = path.path_valid ? n : '0;
  assign busy            = (state != IDLE) && (state != COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (seq_start) begin
      state_n = COLLECT;
    end else begin
      case (state)
`ifdef VITERBI_TB_FWD_ORDER_EN
        COLLECT: if (final_valid) state_n = FILL;
        FILL:    if (n == '0) state_n = TRACE;
`else
        COLLECT: if (final_valid) state_n = TRACE;
`endif
        TRACE:   if (hs && path.path_last) state_n = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt        <= '0;
      err_overflow <= 1'b0;
      n            <= '0;
      s            <= '0;
`ifdef VITERBI_TB_FWD_ORDER_EN
      ptr          <= '0;
`endif
    end else if (seq_start) begin
      t_cnt        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (in_collect && bp_step_done) begin
        if (at_top) err_overflow <= 1'b1;
        else        t_cnt        <= t_cnt + 1'b1;
      end
      if (in_collect && final_valid) begin
        n <= t_cnt_post;
        s <= final_state;
`ifdef VITERBI_TB_FWD_ORDER_EN
        ptr <= '0;
`endif
      end
`ifdef VITERBI_TB_FWD_ORDER_EN
      // FILL walks back while pushing; emission then pops and counts n upward
      if (state == FILL) begin
        ptr <= ptr + 1'b1;
        if (n != '0) begin
          s <= rd_data;
          n <= n - 1'b1;
        end
      end
      if (state == TRACE && hs) begin
        ptr <= ptr - 1'b1;
        n   <= n + 1'b1;
      end
`else
      if (state == TRACE && hs && n != '0) begin
        s <= rd_data;
        n <= n - 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed scoreboard bench for viterbi_traceback; expected paths come from a backpointer model.
module tb_viterbi_traceback;
  import viterbi_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_start, bp_valid, bp_step_done, final_valid;
  logic [SW-1:0] bp_state, final_state;
  logic [31:0]   bp_idx;
  logic          busy, err_overflow;

  viterbi_traceback_if pif ();

  viterbi_traceback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seq_start    (seq_start),
    .bp_valid     (bp_valid),
    .bp_state     (bp_state),
    .bp_idx       (bp_idx),
    .bp_step_done (bp_step_done),
    .final_valid  (final_valid),
    .final_state  (final_state),
    .path         (pif),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] st;
    logic [TW-1:0] stp;
    logic          last;
  } ent_t;

  ent_t          exp_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [SW-1:0] mem_m [T_MAX-1][N_STATES];
  int            tcnt_m = 0;
  bit            mon_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && pif.path_valid) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("path_entry", {pif.path_state, pif.path_step, pif.path_last}, 32'(exp_q[0]));
        if (pif.path_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_seq_start();
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    tcnt_m = 0;
  endtask

  task automatic close_row_model();
    if (tcnt_m < T_MAX - 1) tcnt_m++;
  endtask

  // mode 0: every j gets cval; mode 1: random per j
  task automatic write_row(input int mode, input logic [SW-1:0] cval,
                           input bit combined, input bit close);
    logic [SW-1:0] v;
    for (int j = 0; j < N_STATES; j++) begin
      v = (mode != 0) ? SW'($urandom_range(0, N_STATES - 1)) : cval;
      bp_valid = 1'b1;
      bp_state = SW'(j);
      bp_idx   = ($urandom() & ~32'h7) | 32'(v);
      if (tcnt_m < T_MAX - 1) mem_m[tcnt_m][j] = v;
      bp_step_done = combined && close && (j == N_STATES - 1);
      step();
    end
    bp_valid = 1'b0;
    bp_step_done = 1'b0;
    if (close && !combined) begin
      bp_step_done = 1'b1;
      step();
      bp_step_done = 1'b0;
    end
    if (close) close_row_model();
  endtask

  task automatic run_final(input logic [SW-1:0] fs, input bit toggle, input bit with_done);
    ent_t          rev[$];
    logic [SW-1:0] s;
    int            lat, cyc, exp_lat;
    if (with_done) close_row_model();
    s = fs;
    for (int nn = tcnt_m; nn >= 0; nn--) begin
      rev.push_back('{st: s, stp: TW'(nn), last: (nn == 0)});
      if (nn > 0) s = mem_m[nn-1][s];
    end
`ifdef VITERBI_TB_FWD_ORDER_EN
    for (int k = 0; k <= tcnt_m; k++)
      exp_q.push_back('{st: rev[tcnt_m-k].st, stp: TW'(k), last: (k == tcnt_m)});
    exp_lat = tcnt_m + 2;
`else
    foreach (rev[i]) exp_q.push_back(rev[i]);
    exp_lat = 1;
`endif
    pif.path_ready = 1'b1;
    final_valid    = 1'b1;
    final_state    = fs;
    bp_step_done   = with_done;
    step();
    final_valid  = 1'b0;
    bp_step_done = 1'b0;
    lat = 1;
    while (!pif.path_valid && lat < 300) begin
      step();
      lat++;
    end
    chk("first_valid_latency", lat, exp_lat);
    if (toggle) pif.path_ready = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      if (toggle) pif.path_ready = ~pif.path_ready;
      step();
      cyc++;
    end
    chk("drain_in_budget", exp_q.size(), 0);
    chk("busy_after_path", busy, 1'b0);
    chk("valid_after_path", pif.path_valid, 1'b0);
    pif.path_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    seq_start = 1'b0; bp_valid = 1'b0; bp_step_done = 1'b0; final_valid = 1'b0;
    bp_state = '0; final_state = '0; bp_idx = '0;
    pif.path_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_valid", pif.path_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err_overflow, 1'b0);

    // final_valid in IDLE must not start a traceback
    final_valid = 1'b1; final_state = 3'd5;
    step();
    final_valid = 1'b0;
    step();
    chk("idle_final_busy", busy, 1'b0);
    chk("idle_final_valid", pif.path_valid, 1'b0);

    // three constant rows, ready held high: (3,4),(2,1),(1,5),(0,2)
    do_seq_start();
    write_row(0, 3'd2, 1'b0, 1'b1);
    write_row(0, 3'd5, 1'b1, 1'b1);
    write_row(0, 3'd1, 1'b0, 1'b1);
    chk("busy_in_collect", busy, 1'b0);
    run_final(3'd4, 1'b0, 1'b0);

    // same vector with ready toggling
    do_seq_start();
    write_row(0, 3'd2, 1'b0, 1'b1);
    write_row(0, 3'd5, 1'b0, 1'b1);
    write_row(0, 3'd1, 1'b1, 1'b1);
    run_final(3'd4, 1'b1, 1'b0);

    // zero rows: single entry (0,6)
    do_seq_start();
    run_final(3'd6, 1'b0, 1'b0);

    // random rows, last row closed in the same cycle as final_valid
    do_seq_start();
    for (int r = 0; r < 4; r++) write_row(1, '0, r[0], 1'b1);
    write_row(1, '0, 1'b0, 1'b0);
    run_final(SW'($urandom_range(0, N_STATES - 1)), 1'b1, 1'b1);

    // abort with seq_start while stalled in TRACE
    do_seq_start();
    write_row(0, 3'd3, 1'b0, 1'b1);
    mon_en = 1'b0;
    pif.path_ready = 1'b0;
    final_valid = 1'b1; final_state = 3'd1;
    step();
    final_valid = 1'b0;
    chk("abort_pre_valid", pif.path_valid, 1'b1);
    chk("abort_pre_busy", busy, 1'b1);
    do_seq_start();
    chk("abort_valid", pif.path_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);

    // asynchronous reset while stalled in TRACE
    write_row(0, 3'd7, 1'b0, 1'b1);
    final_valid = 1'b1; final_state = 3'd2;
    step();
    final_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", pif.path_valid, 1'b0);
    chk("rst_mid_state", pif.path_state, '0);
    chk("rst_mid_step", pif.path_step, '0);
    chk("rst_mid_last", pif.path_last, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_err", err_overflow, 1'b0);
    step();
    rst_n = 1'b1;
    pif.path_ready = 1'b1;
    mon_en = 1'b1;
    step();
    chk("rst_mid_idle_valid", pif.path_valid, 1'b0);

    // overflow: 63 closes fill every row, the 64th overflows
    do_seq_start();
    bp_step_done = 1'b1;
    repeat (T_MAX - 1) step();
    chk("ovf_before", err_overflow, 1'b0);
    step();
    chk("ovf_set", err_overflow, 1'b1);
    step();
    bp_step_done = 1'b0;
    chk("ovf_sticky", err_overflow, 1'b1);
    do_seq_start();
    chk("ovf_cleared", err_overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
Consumer end of the Viterbi max-plus reduction. Captures per-step backpointers (argmax indices produced by the PE chain's reduction) into a step-indexed store. On receiving the final-step best state, it walks the store backwards and emits the decoded state path over a valid/ready stream. It sits between the systolic PE wrapper and the downstream path consumer.

Parameters:
N_STATES, 8, number of HMM states (j range)
SW, 3, state index width, clog2(N_STATES)
T_MAX, 64, max observations per sequence; backpointer rows = T_MAX-1
TW, 6, step index width, clog2(T_MAX)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
seq_start  in  1  one-cycle pulse; clears step counter, enters COLLECT
bp_valid  in  1  backpointer write strobe
bp_state  in  SW  destination state j of this backpointer
bp_idx  in  32  argmax from PE reduction; low SW bits used
bp_step_done  in  1  closes current step row
final_valid  in  1  pulse; final-step argmax available, starts traceback
final_state  in  SW  argmax of delta at last step
path_valid  out  1  path entry valid
path_state  out  SW  decoded state
path_step  out  TW  time index n of path_state
path_last  out  1  marks final emitted entry
path_ready  in  1  downstream accept
busy  out  1  high in TRACE/EMIT
err_overflow  out  1  sticky; step count exceeded T_MAX-1 rows

Behaviour:
- Reset: all outputs 0, FSM IDLE, row counter t_cnt=0, err_overflow=0; store contents undefined and never read before being written.
- FSM: IDLE -> COLLECT on seq_start. COLLECT -> TRACE on final_valid. TRACE -> IDLE on handshake of path_last. seq_start in any state -> COLLECT, t_cnt=0, path_valid dropped next cycle (abort).
- COLLECT: bp_valid writes mem[t_cnt][bp_state] = bp_idx[SW-1:0]. bp_state >= N_STATES is ignored. bp_step_done increments t_cnt. When bp_valid and bp_step_done occur in the same cycle, the write lands in the current row, then the row advances.
- Overflow: bp_step_done with t_cnt==T_MAX-1 sets err_overflow; t_cnt saturates; further writes are dropped. err_overflow clears only on reset or seq_start.
- final_valid is sampled after any same-cycle bp_step_done. Traceback latches n=t_cnt (post-increment) and s=final_state.
- TRACE/EMIT: path_valid rises the cycle after final_valid, with path_state=s and path_step=n. On each handshake (valid&ready): if n==0, done; else s <= mem[n-1][s], n <= n-1. path_last=1 when n==0. Throughput is 1 entry/cycle with combinational store read. Outputs hold stable while valid&!ready.
- Emission order is reverse time (n = t_cnt down to 0); total entries = t_cnt+1.
- t_cnt==0 at final_valid: single entry, step 0, path_last=1.
- bp_valid, bp_step_done and final_valid outside COLLECT: ignored. final_valid in IDLE: ignored.
- busy = (state != IDLE && state != COLLECT).

Optional Feature:
VITERBI_TB_FWD_ORDER_EN: when defined, the traceback first pushes t_cnt+1 states into an internal T_MAX-deep LIFO with no output, then pops them with path_step ascending 0..t_cnt. path_valid first rises t_cnt+2 cycles after final_valid. When undefined, the LIFO is absent and reverse-order emission applies as above.

Decomposition:
- Package viterbi_pkg holds N_STATES, SW, T_MAX, TW and the FSM state encoding (IDLE, COLLECT, TRACE, plus FILL when the feature is enabled).
- One sub-module, viterbi_bp_mem: a (T_MAX-1) x N_STATES x SW register array with a synchronous write port and a combinational read port.

Test Plan:
- Reset mid-TRACE with path_ready=0 -> next cycle all outputs 0, FSM IDLE, err_overflow=0.
- N_STATES=8, 3 steps of backpointers (step0 all j->2, step1 all j->5, step2 all j->1), final_state=4, ready held 1 -> entries (3,4),(2,1),(1,5),(0,2); path_last on the 4th; busy drops after.
- Same as above with path_ready toggling 1/0 -> identical sequence; outputs stable while stalled.
- seq_start then immediate final_valid with final_state=6 -> one entry (0,6) with path_last=1.
- 64 bp_step_done pulses with T_MAX=64 -> err_overflow=1 on the 64th; seq_start clears it.
- With VITERBI_TB_FWD_ORDER_EN, vector of the second scenario -> (0,2),(1,5),(2,1),(3,4); first valid 5 cycles after final_valid.
